// File: rtl/fifo_wr_sched_pkg.sv
// Shared constants and Gray-code helpers for the FIFO write scheduler.
// Optional feature macro: FIFO_WR_SCHED_ALMOST_FULL_EN (adds almost_full).
package fifo_wr_sched_pkg;

   localparam int N_REQ_DEF    = 4;
   localparam int DATA_W_DEF   = 8;
   localparam int ADDR_W_DEF   = 4;
   localparam int AF_LEVEL_DEF = 12;

   // Helpers work on a wide container; callers zero-extend and truncate.
   localparam int PTR_W_MAX = 16;
   typedef logic [PTR_W_MAX-1:0] ptr_wide_t;

   function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
      return b ^ (b >> 1);
   endfunction

   // Leading zeros from zero-extension do not disturb the prefix XOR.
   function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
      ptr_wide_t b;
      b = '0;
      b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
      for (int i = PTR_W_MAX-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Requester/FIFO-side bus of the write scheduler.
// Optional feature macro: FIFO_WR_SCHED_ALMOST_FULL_EN (adds almost_full).
interface fifo_wr_sched_if
   import fifo_wr_sched_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] wdata_in;
   logic [ADDR_W:0]         rptr_gray_sync;
   logic [N_REQ-1:0]        gnt;
   logic                    wr_en;
   logic [ADDR_W-1:0]       waddr;
   logic [DATA_W-1:0]       wdata;
   logic [ADDR_W:0]         wptr_gray;
   logic                    full;
`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
   logic                    almost_full;
`endif

   // Requesters and the read-pointer synchronizer drive this side.
   modport master (
      output req, wdata_in, rptr_gray_sync,
      input  gnt, wr_en, waddr, wdata, wptr_gray, full
`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
      , input almost_full
`endif
   );

   // The scheduler itself.
   modport slave (
      input  req, wdata_in, rptr_gray_sync,
      output gnt, wr_en, waddr, wdata, wptr_gray, full
`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
      , output almost_full
`endif
   );

endinterface

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// Round-robin arbiter: search starts at pointer p and wraps at N_REQ;
// p moves to one past the winner after each grant.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   output logic [N_REQ-1:0] gnt
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    p_q;
   logic [PW-1:0]    p_d;
   logic [PW-1:0]    sel_s;
   logic             hit_s;
   logic [N_REQ-1:0] gnt_s;
   logic [PW:0]      sum_s;
   logic [PW-1:0]    idx_s;

   // First asserted request at or after p wins; reset suppresses any grant.
   always_comb begin
      gnt_s = '0;
      hit_s = 1'b0;
      sel_s = '0;
      sum_s = '0;
      idx_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum_s = {1'b0, p_q} + (PW+1)'(k);
         sum_s = (sum_s >= (PW+1)'(N_REQ)) ? (sum_s - (PW+1)'(N_REQ)) : sum_s;
         idx_s = sum_s[PW-1:0];
         if (en && !rst && !hit_s && req[idx_s]) begin
            gnt_s[idx_s] = 1'b1;
            hit_s        = 1'b1;
            sel_s        = idx_s;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Next priority pointer: one past the winner, held when idle.
   always_comb begin
      if (hit_s) begin
         p_d = (sel_s == PW'(N_REQ-1)) ? '0 : (sel_s + PW'(1));
      end else begin
         p_d = p_q;
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign gnt = gnt_s;

endmodule

// File: rtl/fifo_wr_sched.sv
// FIFO write-side scheduler: arbitrates N_REQ writers into one FIFO write
// port, keeps the binary/Gray write pointers and the full flag.
// Optional feature macro: FIFO_WR_SCHED_ALMOST_FULL_EN (adds almost_full).
module fifo_wr_sched
   import fifo_wr_sched_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int AF_LEVEL = AF_LEVEL_DEF
) (
   input logic            clk,
   input logic            rst,
   fifo_wr_sched_if.slave bus
);
   localparam int PTR_W = ADDR_W + 1;

   logic [N_REQ-1:0]  gnt_s;
   logic              wr_en_s;
   logic [DATA_W-1:0] wdata_s;
   logic [PTR_W-1:0]  wbin_q;
   logic [PTR_W-1:0]  wbin_d;
   logic [PTR_W-1:0]  gray_d;
   logic [PTR_W-1:0]  wptr_gray_q;
   logic [PTR_W-1:0]  full_cmp_s;
   logic              full_q;
   logic              full_d;
`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
   logic [PTR_W-1:0]  rptr_bin_s;
   logic              af_q;
   logic              af_d;
`endif

   // Grants are blocked while the FIFO is full.
   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (bus.req),
      .en  (!full_q),
      .gnt (gnt_s)
   );

   // Data mux: granted slice, zero when nobody is granted.
   always_comb begin
      wdata_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_s[i]) begin
            wdata_s = wdata_s | bus.wdata_in[i*DATA_W +: DATA_W];
         end else begin
            wdata_s = wdata_s;
         end
      end
   end

   // Pointer next-state and full detection against the synchronized read pointer.
   always_comb begin
      wr_en_s    = |gnt_s;
      wbin_d     = wbin_q + {{(PTR_W-1){1'b0}}, wr_en_s};
      gray_d     = PTR_W'(bin2gray(ptr_wide_t'(wbin_d)));
      full_cmp_s = {~bus.rptr_gray_sync[ADDR_W:ADDR_W-1], bus.rptr_gray_sync[ADDR_W-2:0]};
      full_d     = (gray_d == full_cmp_s);
   end

   // Write pointer (binary and Gray) and full flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin_q      <= '0;
         wptr_gray_q <= '0;
         full_q      <= 1'b0;
      end else begin
         wbin_q      <= wbin_d;
         wptr_gray_q <= gray_d;
         full_q      <= full_d;
      end
   end

`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
   // Occupancy after this cycle's write compared with the threshold.
   always_comb begin
      rptr_bin_s = PTR_W'(gray2bin(ptr_wide_t'(bus.rptr_gray_sync)));
      af_d       = ((wbin_d - rptr_bin_s) >= PTR_W'(AF_LEVEL));
   end

   // Almost-full register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         af_q <= 1'b0;
      end else begin
         af_q <= af_d;
      end
   end

   assign bus.almost_full = af_q;
`endif

   assign bus.gnt       = gnt_s;
   assign bus.wr_en     = wr_en_s;
   assign bus.waddr     = wbin_q[ADDR_W-1:0];
   assign bus.wdata     = wdata_s;
   assign bus.wptr_gray = wptr_gray_q;
   assign bus.full      = full_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched (N_REQ=4, DATA_W=8, ADDR_W=4).
// Optional feature macro: FIFO_WR_SCHED_ALMOST_FULL_EN (checks almost_full).
module tb_fifo_wr_sched;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   fifo_wr_sched_if #(.N_REQ(4), .DATA_W(8), .ADDR_W(4)) bus ();

   fifo_wr_sched #(.N_REQ(4), .DATA_W(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] g5(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [3:0] exp_gnt_b [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [4:0] prev_gray;
   logic [4:0] cnt5;

   initial begin
      // Reset with all requesters active: nothing may be granted.
      rst                = 1'b1;
      bus.req            = 4'b1111;
      bus.wdata_in       = 32'hA3A2_A1A0;
      bus.rptr_gray_sync = 5'b00000;
      step();
      step();
      chk("rst_gnt",   32'(bus.gnt),       32'h0);
      chk("rst_wr_en", 32'(bus.wr_en),     32'h0);
      chk("rst_wdata", 32'(bus.wdata),     32'h0);
      chk("rst_waddr", 32'(bus.waddr),     32'h0);
      chk("rst_wptr",  32'(bus.wptr_gray), 32'h0);
      chk("rst_full",  32'(bus.full),      32'h0);
`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
      chk("rst_af",    32'(bus.almost_full), 32'h0);
`endif
      rst = 1'b0;
      #1;

      // All four requesting: strict rotation 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         chk("rr_gnt",   32'(bus.gnt),   32'(exp_gnt_b[k]));
         chk("rr_waddr", 32'(bus.waddr), 32'(k));
         chk("rr_wdata", 32'(bus.wdata), 32'(8'hA0 + (k % 4)));
         chk("rr_wr_en", 32'(bus.wr_en), 32'h1);
         step();
      end
      chk("rr_wptr5", 32'(bus.wptr_gray), 32'h07);

      // Sparse requests 0 and 3 with p=1: 3 wins, then 0.
      bus.req = 4'b1001;
      #1;
      chk("sp_gnt0",   32'(bus.gnt),   32'h8);
      chk("sp_waddr0", 32'(bus.waddr), 32'h5);
      chk("sp_wdata0", 32'(bus.wdata), 32'hA3);
      step();
      chk("sp_gnt1",   32'(bus.gnt),   32'h1);
      chk("sp_waddr1", 32'(bus.waddr), 32'h6);
      chk("sp_wdata1", 32'(bus.wdata), 32'hA0);
      step();

      // Burst at waddr 7 (p=1), then asynchronous reset mid-cycle.
      bus.req = 4'b1111;
      #1;
      chk("mid_gnt",   32'(bus.gnt),   32'h2);
      chk("mid_waddr", 32'(bus.waddr), 32'h7);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_gnt",   32'(bus.gnt),       32'h0);
      chk("arst_wr_en", 32'(bus.wr_en),     32'h0);
      chk("arst_wdata", 32'(bus.wdata),     32'h0);
      chk("arst_waddr", 32'(bus.waddr),     32'h0);
      chk("arst_wptr",  32'(bus.wptr_gray), 32'h0);
      chk("arst_full",  32'(bus.full),      32'h0);
      step();
      rst = 1'b0;
      #1;
      chk("post_gnt",   32'(bus.gnt),   32'h1);
      chk("post_waddr", 32'(bus.waddr), 32'h0);

      // Single requester fills all 16 entries with rptr at 0.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      bus.req = 4'b0001;
      #1;
      for (int k = 0; k < 16; k++) begin
         chk("fill_gnt",   32'(bus.gnt),   32'h1);
         chk("fill_waddr", 32'(bus.waddr), 32'(k));
         chk("fill_full",  32'(bus.full),  32'h0);
         step();
`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
         chk("fill_af", 32'(bus.almost_full), 32'((k + 1) >= 12));
`endif
      end
      chk("full_set",   32'(bus.full),      32'h1);
      chk("full_wptr",  32'(bus.wptr_gray), 32'h18);
      chk("full_gnt",   32'(bus.gnt),       32'h0);
      chk("full_wr_en", 32'(bus.wr_en),     32'h0);
      chk("full_wdata", 32'(bus.wdata),     32'h0);
      chk("full_waddr", 32'(bus.waddr),     32'h0);
      step();
      chk("full_hold",     32'(bus.full), 32'h1);
      chk("full_hold_gnt", 32'(bus.gnt),  32'h0);

      // Read side frees one entry: full drops for exactly one write.
      bus.rptr_gray_sync = 5'b00001;
      #1;
      chk("rd_full_still", 32'(bus.full), 32'h1);
      chk("rd_gnt_still",  32'(bus.gnt),  32'h0);
      step();
      chk("rd_full_clr", 32'(bus.full),  32'h0);
      chk("rd_gnt",      32'(bus.gnt),   32'h1);
      chk("rd_wr_en",    32'(bus.wr_en), 32'h1);
      chk("rd_waddr",    32'(bus.waddr), 32'h0);
      step();
      chk("rd_full_again", 32'(bus.full),      32'h1);
      chk("rd_gnt_off",    32'(bus.gnt),       32'h0);
      chk("rd_wptr",       32'(bus.wptr_gray), 32'h19);
`ifdef FIFO_WR_SCHED_ALMOST_FULL_EN
      chk("rd_af", 32'(bus.almost_full), 32'h1);
`endif

      // 40 writes with the read pointer trailing by 3: wraps, never full.
      rst = 1'b1;
      bus.rptr_gray_sync = 5'b00000;
      #1;
      rst = 1'b0;
      #1;
      prev_gray = bus.wptr_gray;
      for (int k = 0; k < 40; k++) begin
         chk("lag_waddr", 32'(bus.waddr), 32'(k % 16));
         chk("lag_gnt",   32'(bus.gnt),   32'h1);
         chk("lag_full",  32'(bus.full),  32'h0);
         step();
         cnt5 = 5'((k + 1) % 32);
         chk("lag_wptr",   32'(bus.wptr_gray), 32'(g5(cnt5)));
         chk("lag_onebit", 32'($countones(prev_gray ^ bus.wptr_gray)), 32'h1);
         prev_gray = bus.wptr_gray;
         bus.rptr_gray_sync = ((k + 1) >= 3) ? g5(5'((k + 1 - 3) % 32)) : 5'b00000;
      end
      chk("lag_full_end", 32'(bus.full), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
